// File: rtl/mem_access_unit_if.sv
// Request/response and memory-side bundle between the control FSM, the memory and mem_access_unit.
// The misaligned flag exists only when ALIGN_CHECK_EN is defined.
interface mem_access_unit_if;
    logic        start;
    logic [31:0] addressIn;
    logic [2:0]  op;
    logic [31:0] storeData;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] loadData;
    logic        busy;
    logic        done;
`ifdef ALIGN_CHECK_EN
    logic        misaligned;
`endif

    modport master (
        output start, addressIn, op, storeData, mem_rdata,
        input  mem_addr, mem_wr, mem_wdata, loadData, busy, done
`ifdef ALIGN_CHECK_EN
        , input misaligned
`endif
    );

    modport slave (
        input  start, addressIn, op, storeData, mem_rdata,
        output mem_addr, mem_wr, mem_wdata, loadData, busy, done
`ifdef ALIGN_CHECK_EN
        , output misaligned
`endif
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer for a word-wide synchronous memory: sized loads, read-modify-write sub-word stores.
// Optional alignment fault detection is enabled by defining ALIGN_CHECK_EN.
module mem_access_unit #(
    parameter int MEM_LATENCY = 1
) (
    input logic              clk,
    input logic              reset,
    mem_access_unit_if.slave bus
);
    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LB  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;
    localparam logic [2:0] LAST_CNT = 3'(MEM_LATENCY);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [2:0]  op_reg, op_next;
    logic [1:0]  lo_reg, lo_next;
    logic [15:0] sdata_reg, sdata_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;
    logic [31:0] load_reg, load_next;
    logic        mem_wr_reg, mem_wr_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic [31:0] merged;
`ifdef ALIGN_CHECK_EN
    logic        mis_reg, mis_next;

    function automatic logic is_misaligned(input logic [2:0] o, input logic [1:0] lo);
        case (o)
            OP_LW, OP_SW:         return lo != 2'b00;
            OP_LH, OP_LHU, OP_SH: return lo[0];
            default:              return 1'b0;
        endcase
    endfunction
`endif

    function automatic logic [31:0] extend_load(input logic [31:0] w, input logic [2:0] o,
                                                input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {lo, 3'b000});
        h = 16'(w >> {lo[1], 4'b0000});
        case (o)
            OP_LH:   return {{16{h[15]}}, h};
            OP_LB:   return {{24{b[7]}}, b};
            OP_LHU:  return {16'h0000, h};
            OP_LBU:  return {24'h000000, b};
            default: return w;
        endcase
    endfunction

    // Sub-word store merge: each byte lane takes store data if addressed, else keeps the read word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic lane_sel;
            assign lane_sel = (op_reg == OP_SB) ? (lo_reg == 2'(gi)) : (lo_reg[1] == 1'(gi / 2));
            assign merged[8*gi +: 8] = !lane_sel ? bus.mem_rdata[8*gi +: 8] :
                                       ((op_reg == OP_SB) || (gi % 2 == 0)) ? sdata_reg[7:0] :
                                       sdata_reg[15:8];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        op_next        = op_reg;
        lo_next        = lo_reg;
        sdata_next     = sdata_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        load_next      = load_reg;
        mem_wr_next    = 1'b0;
        done_next      = 1'b0;
`ifdef ALIGN_CHECK_EN
        mis_next       = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    op_next    = bus.op;
                    lo_next    = bus.addressIn[1:0];
                    sdata_next = bus.storeData[15:0];
`ifdef ALIGN_CHECK_EN
                    if (is_misaligned(bus.op, bus.addressIn[1:0])) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                        mis_next   = 1'b1;
                    end else
`endif
                    if (bus.op == OP_SW) begin
                        mem_addr_next  = {bus.addressIn[31:2], 2'b00};
                        mem_wdata_next = bus.storeData;
                        mem_wr_next    = 1'b1;
                        state_next     = WRITE;
                    end else begin
                        mem_addr_next = {bus.addressIn[31:2], 2'b00};
                        cnt_next      = 3'd0;
                        state_next    = READ;
                    end
                end
            end
            READ: begin
                if (cnt_reg == LAST_CNT) begin
                    cnt_next = 3'd0;
                    if (op_reg == OP_SH || op_reg == OP_SB) begin
                        mem_wdata_next = merged;
                        mem_wr_next    = 1'b1;
                        state_next     = WRITE;
                    end else begin
                        load_next  = extend_load(bus.mem_rdata, op_reg, lo_reg);
                        done_next  = 1'b1;
                        state_next = DONE;
                    end
                end else begin
                    cnt_next = cnt_reg + 3'd1;
                end
            end
            WRITE: begin
                done_next  = 1'b1;
                state_next = DONE;
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= 3'd0;
            op_reg        <= 3'd0;
            lo_reg        <= 2'd0;
            sdata_reg     <= 16'd0;
            mem_addr_reg  <= 32'd0;
            mem_wdata_reg <= 32'd0;
            load_reg      <= 32'd0;
            mem_wr_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
`ifdef ALIGN_CHECK_EN
            mis_reg       <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            op_reg        <= op_next;
            lo_reg        <= lo_next;
            sdata_reg     <= sdata_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            load_reg      <= load_next;
            mem_wr_reg    <= mem_wr_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
`ifdef ALIGN_CHECK_EN
            mis_reg       <= mis_next;
`endif
        end
    end

    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wr    = mem_wr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.loadData  = load_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
`ifdef ALIGN_CHECK_EN
    assign bus.misaligned = mis_reg;
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: latency-based transaction model checked every cycle, plus literal pins.
// Honours ALIGN_CHECK_EN the same way as the design.
module tb_mem_access_unit;
    localparam int L = 1;
    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LB = 3'd2, LHU = 3'd3, LBU = 3'd4,
                           SW = 3'd5, SH = 3'd6, SB = 3'd7;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    mem_access_unit_if bus();
    mem_access_unit #(.MEM_LATENCY(L)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment memory: address registered at an edge, data visible L edges later.
    logic [31:0] mem [0:1023];
    logic [31:0] pipe [0:L-1];
    logic        pl_we = 1'b0;
    logic [9:0]  pl_idx = 10'd0;
    logic [31:0] pl_data = 32'd0;
    always @(posedge clk) begin
        if (pl_we) mem[pl_idx] <= pl_data;
        else if (bus.mem_wr) mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
        pipe[0] <= mem[bus.mem_addr[11:2]];
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.mem_rdata = pipe[L-1];

    // Transaction model (owned by the stimulus process); timing relative to the start edge k.
    logic [31:0] ref_mem [0:1023];
    int          m_k = -100;
    logic        m_valid = 1'b0;
    logic        m_fault = 1'b0;
    logic        m_is_load = 1'b0;
    int          m_done_rel = 0;
    int          m_wr_rel = -1;
    logic [31:0] m_ld = 32'd0;
    logic [31:0] m_wdata = 32'd0;
    logic [31:0] m_waddr = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] word, v;
        int sh;
        word      = ref_mem[a[11:2]];
        m_k       = cyc + 1;
        m_valid   = 1'b1;
        m_fault   = 1'b0;
        m_is_load = (o <= LBU);
        m_wr_rel  = -1;
        m_waddr   = a & 32'hFFFF_FFFC;
`ifdef ALIGN_CHECK_EN
        m_fault = ((o == LW || o == SW) && a[1:0] != 2'b00) ||
                  ((o == LH || o == LHU || o == SH) && a[0]);
`endif
        if (m_fault) begin
            m_done_rel = 0;
            m_is_load  = 1'b0;
        end else begin
            // Spec latencies are counted from cycle k+1, i.e. rel 0 here.
            case (o)
                LW: begin m_ld = word; m_done_rel = L + 1; end
                LH, LHU: begin
                    sh = 16 * int'(a[1]);
                    v  = (word >> sh) & 32'h0000_FFFF;
                    if (o == LH && v >= 32'h8000) v = v - 32'h1_0000;
                    m_ld = v; m_done_rel = L + 1;
                end
                LB, LBU: begin
                    sh = 8 * int'(a[1:0]);
                    v  = (word >> sh) & 32'h0000_00FF;
                    if (o == LB && v >= 32'h80) v = v - 32'h100;
                    m_ld = v; m_done_rel = L + 1;
                end
                SW: begin m_wdata = d; m_wr_rel = 0; m_done_rel = 1; end
                SH: begin
                    sh = 16 * int'(a[1]);
                    m_wdata = (word & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
                    m_wr_rel = L + 1; m_done_rel = L + 2;
                end
                default: begin
                    sh = 8 * int'(a[1:0]);
                    m_wdata = (word & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
                    m_wr_rel = L + 1; m_done_rel = L + 2;
                end
            endcase
            if (!m_is_load) ref_mem[a[11:2]] = m_wdata;
        end
    endtask

    // Per-cycle compare process.
    logic        rst_q = 1'b1;
    int          kill_k = -1;
    logic [31:0] ld_exp = 32'd0;
    always @(posedge clk) rst_q <= reset;

    always @(negedge clk) begin : cmp
        int rel;
        logic act, e_done, e_wr;
        logic [31:0] ld_now;
        if (rst_q) begin
            kill_k <= m_k;
            ld_exp <= 32'd0;
            chk("rst_busy", 32'(bus.busy), 32'd0);
            chk("rst_done", 32'(bus.done), 32'd0);
            chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
            chk("rst_mem_addr", bus.mem_addr, 32'd0);
            chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
            chk("rst_loadData", bus.loadData, 32'd0);
`ifdef ALIGN_CHECK_EN
            chk("rst_misaligned", 32'(bus.misaligned), 32'd0);
`endif
        end else begin
            rel    = cyc - m_k;
            act    = m_valid && (kill_k != m_k) && rel >= 0 && rel <= m_done_rel;
            e_done = act && rel == m_done_rel;
            e_wr   = act && rel == m_wr_rel;
            ld_now = (e_done && m_is_load) ? m_ld : ld_exp;
            ld_exp <= ld_now;
            chk("done", 32'(bus.done), 32'(e_done));
            chk("busy", 32'(bus.busy), 32'(act));
            chk("mem_wr", 32'(bus.mem_wr), 32'(e_wr));
            chk("loadData", bus.loadData, ld_now);
            if (act && !m_fault) chk("mem_addr", bus.mem_addr, m_waddr);
            if (e_wr) chk("mem_wdata", bus.mem_wdata, m_wdata);
`ifdef ALIGN_CHECK_EN
            chk("misaligned", 32'(bus.misaligned), 32'(e_done && m_fault));
`endif
        end
    end

    task automatic poke(input logic [9:0] idx, input logic [31:0] data);
        @(negedge clk);
        pl_we = 1'b1; pl_idx = idx; pl_data = data;
        ref_mem[idx] = data;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // One request; extra_rel >= 0 drives an unrelated start at that relative cycle.
    task automatic do_req(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] d, input int extra_rel, input int exp_lat);
        int   lat;
        logic got;
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.addressIn = a; bus.storeData = d;
        model_issue(o, a, d);
        lat = 0;
        got = 1'b0;
        while (lat < 40 && !got) begin
            @(negedge clk);
            lat++;
            if (lat - 1 == extra_rel) begin
                bus.start = 1'b1; bus.op = SB; bus.addressIn = 32'h200; bus.storeData = 32'h0;
            end else begin
                bus.start = 1'b0; bus.op = 3'($urandom_range(0, 7)); bus.addressIn = $urandom;
                bus.storeData = $urandom;
            end
            if (bus.done === 1'b1) got = 1'b1;
        end
        chk({name, "_done_seen"}, 32'(got), 32'd1);
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        @(negedge clk);
        bus.start = 1'b0;
        $display("txn %s op=%0d addr=%h wdata=%h latency=%0d loadData=%h",
                 name, o, a, d, lat, bus.loadData);
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 3'd0; bus.addressIn = 32'd0; bus.storeData = 32'd0;
        reset = 1'b1;
        poke(10'h041, 32'hDEAD_BEEF);
        poke(10'h080, 32'h1122_3344);
        poke(10'h040, 32'h0BAD_F00D);
        poke(10'h3FF, 32'h7F00_0000);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        do_req("lw_104", LW, 32'h104, 32'h0, -1, 3);
        chk("lw_104_value", bus.loadData, 32'hDEAD_BEEF);
        do_req("sw_104", SW, 32'h104, 32'h80FF_1234, -1, 2);
        chk("sw_104_loadData_kept", bus.loadData, 32'hDEAD_BEEF);
        do_req("lb_107", LB, 32'h107, 32'h0, -1, 3);
        chk("lb_107_value", bus.loadData, 32'hFFFF_FF80);
        do_req("lbu_107", LBU, 32'h107, 32'h0, -1, 3);
        chk("lbu_107_value", bus.loadData, 32'h0000_0080);
        do_req("lh_106", LH, 32'h106, 32'h0, -1, 3);
        chk("lh_106_value", bus.loadData, 32'hFFFF_80FF);
        do_req("lhu_106", LHU, 32'h106, 32'h0, -1, 3);
        chk("lhu_106_value", bus.loadData, 32'h0000_80FF);
        do_req("lb_104", LB, 32'h104, 32'h0, -1, 3);
        do_req("sb_202", SB, 32'h202, 32'h0000_00AB, -1, 4);
        chk("sb_202_mem", mem[10'h080], 32'h11AB_3344);
        chk("sb_202_loadData_kept", bus.loadData, 32'h0000_0034);
        do_req("sh_202", SH, 32'h202, 32'h5555_BEEF, -1, 4);
        chk("sh_202_mem", mem[10'h080], 32'hBEEF_3344);
        do_req("sw_300", SW, 32'h300, 32'hCAFE_F00D, 0, 2);
        chk("sw_300_mem", mem[10'h0C0], 32'hCAFE_F00D);
        chk("sw_300_no_extra_write", mem[10'h080], 32'hBEEF_3344);
        do_req("lw_300", LW, 32'h300, 32'h0, -1, 3);
        chk("lw_300_value", bus.loadData, 32'hCAFE_F00D);
        do_req("lb_wrap", LB, 32'hFFFF_FFFF, 32'h0, L + 1, 3);
        chk("lb_wrap_value", bus.loadData, 32'h0000_007F);
`ifdef ALIGN_CHECK_EN
        do_req("lw_102_fault", LW, 32'h102, 32'h0, -1, 1);
        chk("lw_102_loadData_kept", bus.loadData, 32'h0000_007F);
        do_req("sw_301_fault", SW, 32'h301, 32'h1234_5678, -1, 1);
        chk("sw_301_mem_kept", mem[10'h0C0], 32'hCAFE_F00D);
`else
        do_req("lw_102", LW, 32'h102, 32'h0, -1, 3);
        chk("lw_102_value", bus.loadData, 32'h0BAD_F00D);
`endif

        // Reset for two edges while the SW sits in WRITE.
        @(negedge clk);
        bus.start = 1'b1; bus.op = SW; bus.addressIn = 32'h400; bus.storeData = 32'h1234_5678;
        model_issue(SW, 32'h400, 32'h1234_5678);
        @(negedge clk);
        bus.start = 1'b0;
        chk("rst_test_in_write", 32'(bus.mem_wr), 32'd1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_test_loadData", bus.loadData, 32'd0);
        chk("rst_test_mem_addr", bus.mem_addr, 32'd0);
        $display("txn reset_mid_sw addr=00000400 busy=%0d done=%0d", bus.busy, bus.done);

        do_req("lw_104_after_rst", LW, 32'h104, 32'h0, -1, 3);
        chk("lw_104_after_rst_value", bus.loadData, 32'h80FF_1234);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
